adc_nibble_tx: RTL and testbench

ADC-side transmitter for the oven's 4-bit ADC nibble bus: the producer at the far end of the link the oven controller's ADC receiver listens to.
On each conversion request (adc_enable rising edge) it snapshots current temperature, set temperature and set time, waits a conversion delay, then serialises them as five 4-bit nibbles, each qualified by an adc_int strobe.
It is used as the on-board ADC emulator/bridge and as the bench driver for the oven controller.

---
 rtl/adc_nibble_tx_pkg.sv | 49 ++++
 rtl/adc_nibble_tx_edge_sync.sv | 33 +++
 rtl/adc_nibble_tx.sv | 155 +++++++++++++++
 tb/tb_adc_nibble_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_nibble_tx_pkg.sv
// Shared encodings, frame layout and default timing for the ADC nibble transmitter.
// Pulls one nibble of the {current_temp, set_temp, set_time} snapshot by frame index.
package adc_nibble_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONV   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    localparam int NIBBLES_PER_FRAME = 5;

    localparam logic [2:0] IDX_CUR_HI  = 3'd0;
    localparam logic [2:0] IDX_CUR_LO  = 3'd1;
    localparam logic [2:0] IDX_SET_HI  = 3'd2;
    localparam logic [2:0] IDX_SET_LO  = 3'd3;
    localparam logic [2:0] IDX_TIME    = 3'd4;

    localparam int DEF_CONV_CYCLES  = 8;
    localparam int DEF_SETUP_CYCLES = 2;
    localparam int DEF_PULSE_CYCLES = 2;
    localparam int DEF_HOLD_CYCLES  = 2;

    function automatic logic [3:0] nibble_at(input logic [19:0] snap, input logic [2:0] idx);
        logic [3:0] nib;
        case (idx)
            IDX_CUR_HI: nib = snap[19:16];
            IDX_CUR_LO: nib = snap[15:12];
            IDX_SET_HI: nib = snap[11:8];
            IDX_SET_LO: nib = snap[7:4];
            IDX_TIME:   nib = snap[3:0];
            default:    nib = 4'h0;
        endcase
        return nib;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/adc_nibble_tx_edge_sync.sv
// Two-flop synchroniser for an asynchronous level, followed by a one-cycle rising-edge pulse.
module adc_nibble_tx_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/adc_nibble_tx.sv
// ADC-side nibble bus transmitter: snapshots the three values on a request and
// sends them as five strobed nibbles after a conversion delay.
module adc_nibble_tx
    import adc_nibble_tx_pkg::*;
#(
    parameter int CONV_CYCLES  = DEF_CONV_CYCLES,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adc_enable,
    input  logic [7:0] current_temp,
    input  logic [7:0] set_temp,
    input  logic [3:0] set_time,
    output logic [3:0] adc_data,
    output logic       adc_int,
    output logic       busy,
    output logic       frame_done,
    output logic [2:0] dbg_state
);

    localparam int MAX_CYCLES = max4(CONV_CYCLES, SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES);
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CONV_LOAD  = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [2:0]       LAST_IDX   = 3'(NIBBLES_PER_FRAME - 1);

    logic detect;

    adc_nibble_tx_edge_sync u_edge_sync (
        .clk        (clk),
        .rst_n      (rst),
        .async_in   (adc_enable),
        .rise_pulse (detect)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [19:0]      snap_q, snap_d;
    logic [3:0]       data_q, data_d;
    logic             int_q, int_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Strobe protocol: adc_data is valid from SETUP entry until HOLD exit;
    // the receiver samples it on the rising edge of adc_int with no back-pressure.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        data_d  = data_q;
        int_d   = int_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (detect) begin
                    snap_d  = {current_temp, set_temp, set_time};
                    busy_d  = 1'b1;
                    cnt_d   = CONV_LOAD;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (cnt_q == '0) begin
                    idx_d   = IDX_CUR_HI;
                    data_d  = nibble_at(snap_q, IDX_CUR_HI);
                    cnt_d   = SETUP_LOAD;
                    state_d = ST_SETUP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    int_d   = 1'b1;
                    cnt_d   = PULSE_LOAD;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    int_d   = 1'b0;
                    cnt_d   = HOLD_LOAD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    data_d  = 4'h0;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    data_d  = nibble_at(snap_q, idx_q + 3'd1);
                    cnt_d   = SETUP_LOAD;
                    state_d = ST_SETUP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                data_d  = 4'h0;
                int_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            data_q  <= '0;
            int_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            data_q  <= data_d;
            int_q   <= int_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign adc_data   = data_q;
    assign adc_int    = int_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_adc_nibble_tx.sv
// Bench for adc_nibble_tx: a default-timing and an all-ones-timing instance share stimulus
// and are checked every cycle against a frame-timeline model.
module tb_adc_nibble_tx;

  localparam int CV[2] = '{8, 1};
  localparam int SU[2] = '{2, 1};
  localparam int PU[2] = '{2, 1};
  localparam int HO[2] = '{2, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic       adc_enable;
  logic [7:0] current_temp;
  logic [7:0] set_temp;
  logic [3:0] set_time;

  logic [3:0] data_w[2];
  logic       int_w[2];
  logic       busy_w[2];
  logic       fd_w[2];
  logic [2:0] st_w[2];

  adc_nibble_tx u_dut (
    .clk(clk), .rst(rst), .adc_enable(adc_enable),
    .current_temp(current_temp), .set_temp(set_temp), .set_time(set_time),
    .adc_data(data_w[0]), .adc_int(int_w[0]), .busy(busy_w[0]),
    .frame_done(fd_w[0]), .dbg_state(st_w[0])
  );

  adc_nibble_tx #(.CONV_CYCLES(1), .SETUP_CYCLES(1), .PULSE_CYCLES(1), .HOLD_CYCLES(1)) u_fast (
    .clk(clk), .rst(rst), .adc_enable(adc_enable),
    .current_temp(current_temp), .set_temp(set_temp), .set_time(set_time),
    .adc_data(data_w[1]), .adc_int(int_w[1]), .busy(busy_w[1]),
    .frame_done(fd_w[1]), .dbg_state(st_w[1])
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int period(input int i);
    return SU[i] + PU[i] + HO[i];
  endfunction

  function automatic int flen(input int i);
    return CV[i] + 5 * period(i);
  endfunction

  // ---------------- behavioural model ----------------
  bit         act[2];
  int         k[2];
  logic [19:0] snap[2];
  logic [2:0] en_h;
  logic [3:0] exp_q[2][$];

  initial begin
    en_h = '0;
    for (int i = 0; i < 2; i++) begin act[i] = 0; k[i] = 0; snap[i] = '0; end
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        en_h = '0;
        for (int i = 0; i < 2; i++) begin act[i] = 0; k[i] = 0; exp_q[i].delete(); end
      end else begin
        // A request is taken three edges after adc_enable is first sampled high.
        for (int i = 0; i < 2; i++) begin
          if (act[i]) begin
            if (k[i] == flen(i)) act[i] = 0;
            else k[i] = k[i] + 1;
          end else if (en_h[1] && !en_h[2]) begin
            act[i]  = 1;
            k[i]    = 0;
            snap[i] = {current_temp, set_temp, set_time};
            for (int n = 0; n < 5; n++) exp_q[i].push_back(4'((snap[i] >> (4 * (4 - n))) & 20'hF));
          end
        end
        en_h = {en_h[1:0], adc_enable};
      end
    end
  end

  function automatic logic [6:0] model_out(input int i);
    logic       ebusy, eint, efd;
    logic [3:0] edata;
    int j, n, p;
    ebusy = 0; eint = 0; efd = 0; edata = 0;
    if (act[i]) begin
      if (k[i] < CV[i]) begin
        ebusy = 1;
      end else if (k[i] < flen(i)) begin
        j = k[i] - CV[i];
        n = j / period(i);
        p = j % period(i);
        ebusy = 1;
        edata = 4'((snap[i] >> (4 * (4 - n))) & 20'hF);
        eint  = (p >= SU[i]) && (p < SU[i] + PU[i]);
      end else begin
        efd = 1;
      end
    end
    return {ebusy, eint, efd, edata};
  endfunction

  // ---------------- compare / monitor process ----------------
  int         cyc = 0;
  int         st_tot[2], fd_tot[2], st_frame[2], busy_cyc[2], flen_got[2];
  logic [19:0] cap_w[2];
  logic       int_prev[2], busy_prev[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      st_tot[i] = 0; fd_tot[i] = 0; st_frame[i] = 0; busy_cyc[i] = 0; flen_got[i] = 0;
      cap_w[i] = '0; int_prev[i] = 0; busy_prev[i] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("cyc%0d u%0d {busy,int,done,data}", cyc, i),
            {25'b0, busy_w[i], int_w[i], fd_w[i], data_w[i]}, {25'b0, model_out(i)});
        if (busy_w[i] && !busy_prev[i]) begin
          busy_cyc[i] = cyc; st_frame[i] = 0; cap_w[i] = '0;
        end
        if (int_w[i] && !int_prev[i]) begin
          st_tot[i]++; st_frame[i]++;
          cap_w[i] = {cap_w[i][15:0], data_w[i]};
          chk($sformatf("u%0d nibble pending", i), {31'b0, exp_q[i].size() > 0}, 32'd1);
          if (exp_q[i].size() > 0)
            chk($sformatf("u%0d strobed nibble", i), {28'b0, data_w[i]}, {28'b0, exp_q[i].pop_front()});
        end
        if (fd_w[i]) begin
          fd_tot[i]++; flen_got[i] = cyc - busy_cyc[i];
        end
        int_prev[i]  = int_w[i];
        busy_prev[i] = busy_w[i];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic request(input int width);
    @(negedge clk); #1;
    adc_enable = 1'b1;
    repeat (width) @(negedge clk);
    #1 adc_enable = 1'b0;
  endtask

  task automatic wait_frame();
    int base;
    base = fd_tot[0];
    for (int t = 0; t < 150; t++) begin
      @(negedge clk); #1;
      if (fd_tot[0] > base) break;
    end
    chk("frame_done seen", fd_tot[0], base + 1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic wait_strobe_high(input int n);
    for (int t = 0; t < 150; t++) begin
      @(negedge clk); #1;
      if (st_frame[0] >= n && int_w[0]) break;
    end
    chk("reached strobe", st_frame[0], n);
  endtask

  task automatic wait_busy();
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); #1;
      if (busy_w[0]) break;
    end
    chk("busy seen", {31'b0, busy_w[0]}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  int fd_b[2], st_b[2];

  initial begin
    rst = 1'b0; adc_enable = 1'b0;
    current_temp = 8'h00; set_temp = 8'h00; set_time = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset outputs u%0d", i),
          {22'b0, busy_w[i], int_w[i], fd_w[i], data_w[i], st_w[i]}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame, both timings.
    current_temp = 8'hA5; set_temp = 8'h3C; set_time = 4'h7;
    request(3);
    wait_frame();
    chk("t1 u0 frame", {12'b0, cap_w[0]}, 32'hA53C7);
    chk("t1 u1 frame", {12'b0, cap_w[1]}, 32'hA53C7);
    chk("t1 u0 strobes", st_frame[0], 5);
    chk("t1 u0 detect-to-done", flen_got[0], 38);
    chk("t1 u1 detect-to-done", flen_got[1], 16);
    chk("t1 u0 busy low", {31'b0, busy_w[0]}, 32'd0);

    // Input change after snapshot.
    request(2);
    wait_busy();
    current_temp = 8'hFF;
    wait_frame();
    chk("t2 u0 frame", {12'b0, cap_w[0]}, 32'hA53C7);
    chk("t2 u1 frame", {12'b0, cap_w[1]}, 32'hA53C7);

    // Second request during idx2 is dropped.
    current_temp = 8'h12; set_temp = 8'h34; set_time = 4'h5;
    fd_b[0] = fd_tot[0];
    request(2);
    wait_strobe_high(3);
    request(2);
    wait_frame();
    repeat (20) @(negedge clk);
    #1;
    chk("t3 u0 strobes", st_frame[0], 5);
    chk("t3 u0 one done", fd_tot[0], fd_b[0] + 1);
    chk("t3 u0 frame", {12'b0, cap_w[0]}, 32'h12345);
    chk("t3 u0 idle", {31'b0, busy_w[0]}, 32'd0);

    // Level held high: exactly one frame.
    for (int i = 0; i < 2; i++) begin fd_b[i] = fd_tot[i]; st_b[i] = st_tot[i]; end
    @(negedge clk); #1 adc_enable = 1'b1;
    repeat (100) @(negedge clk);
    #1 adc_enable = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t4 u%0d frames", i), fd_tot[i] - fd_b[i], 1);
      chk($sformatf("t4 u%0d strobes", i), st_tot[i] - st_b[i], 5);
    end

    // Asynchronous reset during idx3 strobe, then a clean frame.
    current_temp = 8'h9E; set_temp = 8'h61; set_time = 4'hB;
    request(2);
    wait_strobe_high(4);
    #2 rst = 1'b0;
    #1;
    chk("t5 async adc_int", {31'b0, int_w[0]}, 32'd0);
    chk("t5 async adc_data", {28'b0, data_w[0]}, 32'd0);
    chk("t5 async busy", {31'b0, busy_w[0]}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    request(2);
    wait_frame();
    chk("t5 u0 strobes", st_frame[0], 5);
    chk("t5 u0 frame", {12'b0, cap_w[0]}, 32'h9E61B);

    // Randomised frames, occasionally with a stray mid-frame request.
    for (int r = 0; r < 8; r++) begin
      current_temp = 8'($urandom_range(0, 255));
      set_temp     = 8'($urandom_range(0, 255));
      set_time     = 4'($urandom_range(0, 15));
      request($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(3, 25)) @(negedge clk);
        current_temp = 8'($urandom_range(0, 255));
        request($urandom_range(1, 3));
      end
      wait_frame();
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    #1;
    chk("u0 expected queue drained", exp_q[0].size(), 0);
    chk("u1 expected queue drained", exp_q[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
